nes_dual_poll_sequencer: RTL
============================

Name: nes_dual_poll_sequencer

Overview:
Sequences the NES serial-read protocol for both game controllers from one shared timebase. The left and right controllers share the latch and pulse lines and have separate data lines. Once per poll period the block shifts 8 button bits in from each controller, publishes debounced-by-frame button vectors, and emits one-cycle new-press strobes. These strobes drive the paddle, serve and reset logic in the pong datapath.

Parameters:
HALF_CYCLES, 152, clk cycles per protocol unit (6 us at 25.175 MHz); legal range 2..1023
POLL_CYCLES, 419583, clk cycles per poll period (~60 Hz); must exceed 17*HALF_CYCLES+2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  permits new frames to start; sampled only in WAIT
nes_data_l  in  1  left controller serial data, active-low (0 = pressed)
nes_data_r  in  1  right controller serial data, active-low
nes_latch  out  1  latch line to both controllers, registered
nes_pulse  out  1  clock line to both controllers, registered
buttons_l  out  8  left button state, 1 = pressed; bit order [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right
buttons_r  out  8  right button state, same bit order
press_l  out  8  one-cycle strobe of buttons newly pressed this frame (left)
press_r  out  8  one-cycle strobe (right)
frame_done  out  1  one-cycle strobe when buttons_*/press_* update
busy  out  1  high in any state other than WAIT

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All outputs go to 0.
  - State goes to WAIT.
  - Poll counter, unit counter, bit index and both shift registers are cleared.
  - Reset applies mid-frame too; the partially shifted data is discarded.
- Poll counter:
  - Free-running 0..POLL_CYCLES-1 and wraps to 0; unaffected by state or enable.
  - Terminal count is poll_cnt == POLL_CYCLES-1.
- Unit counter:
  - Counts 0..HALF_CYCLES-1 inside timed states.
  - Clears on every state change.
  - unit_end is the cycle in which unit_cnt == HALF_CYCLES-1.
- States and outputs:
  - WAIT: latch=0, pulse=0. At poll terminal count with enable=1, go to LATCH. If enable=0 at terminal count, that poll is skipped.
  - LATCH: latch=1, pulse=0, for 2*HALF_CYCLES cycles (the unit counter runs twice). Then go to READ with bit index k=0.
  - READ: latch=0, pulse=0, for HALF_CYCLES cycles.
    - On the unit_end cycle, shift nes_data_l and nes_data_r MSB-first into their shift registers. Bit k lands in position 7-k.
    - If k<7, go to PULSE; if k==7, go to DONE.
  - PULSE: pulse=1 for HALF_CYCLES cycles. Then k increments and the state returns to READ.
  - DONE (1 cycle), with new = ~shift:
    - buttons_x <= new
    - press_x <= new & ~buttons_x (using the old buttons_x)
    - frame_done <= 1
    - Next state is WAIT.
- Strobe timing: press_x and frame_done are high for exactly the one cycle after DONE, then return to 0. buttons_x holds its value until the next DONE.
- Frame length:
  - 17*HALF_CYCLES+1 cycles, from first latch-high cycle to frame_done.
  - Exactly one latch pulse per frame.
  - Exactly 7 pulse highs per frame, each HALF_CYCLES cycles wide.
- Registered outputs: nes_latch and nes_pulse are registered and glitch-free. They change only on state transitions.
- Mid-frame enable: deasserting enable mid-frame has no effect; the frame completes.
- Overlapping terminal count: a poll terminal count occurring while not in WAIT is ignored. This cannot happen with legal parameters.
- Simultaneous presses: left and right are shifted on identical cycles. Simultaneous presses on both controllers appear in the same frame_done cycle.

Test Plan:
Use HALF_CYCLES=4 and POLL_CYCLES=100 for all scenarios unless stated.
1. Reset release, data lines idle high, enable=1:
   - All outputs 0 until the first latch.
   - nes_latch rises on the 100th edge after reset release and stays high 8 cycles.
   - frame_done fires 69 cycles after latch rises.
   - buttons_l = buttons_r = 0 and press = 0.
2. Left presses A and Up (nes_data_l low during READ k=0 and k=4), right presses Start (k=3):
   - buttons_l = 8'h88, press_l = 8'h88 for one cycle.
   - buttons_r = 8'h10, press_r = 8'h10.
3. Same buttons held through the next frame:
   - buttons unchanged and press_l = press_r = 0.
   - Then release Up in the third frame: buttons_l = 8'h80, press_l = 0.
4. Protocol waveform check within one frame:
   - nes_pulse has exactly 7 high pulses, each 4 cycles wide, separated by 4-cycle lows.
   - Sampling occurs on the 4th cycle of each READ.
   - busy is high from latch rise through DONE.
5. enable dropped 10 cycles into a frame:
   - The frame completes normally with frame_done.
   - No further nes_latch while enable=0.
   - Re-assert enable: the next latch aligns to the poll terminal count.
6. reset_n pulsed low during a PULSE state with buttons_l = 8'h88:
   - Next cycle nes_pulse = 0, buttons_l = 0, busy = 0.
   - The first post-reset latch arrives 100 cycles later.

Source files
------------

// File: rtl/nes_dual_poll_sequencer_if.sv
// Signal bundle between the dual NES poll sequencer and its surroundings
// (controller pins plus the button/strobe outputs toward the pong datapath).
interface nes_dual_poll_sequencer_if;
    logic       enable;
    logic       nes_data_l;
    logic       nes_data_r;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons_l;
    logic [7:0] buttons_r;
    logic [7:0] press_l;
    logic [7:0] press_r;
    logic       frame_done;
    logic       busy;

    modport master (
        output enable, nes_data_l, nes_data_r,
        input  nes_latch, nes_pulse, buttons_l, buttons_r,
        input  press_l, press_r, frame_done, busy
    );

    modport slave (
        input  enable, nes_data_l, nes_data_r,
        output nes_latch, nes_pulse, buttons_l, buttons_r,
        output press_l, press_r, frame_done, busy
    );
endinterface

// File: rtl/nes_dual_poll_sequencer.sv
// Polls both NES controllers once per poll period over shared latch/pulse lines,
// publishing per-frame button vectors and one-cycle new-press strobes.
module nes_dual_poll_sequencer #(
    parameter int HALF_CYCLES = 152,
    parameter int POLL_CYCLES = 419583
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nes_dual_poll_sequencer_if.slave  bus
);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam int UW = $clog2(HALF_CYCLES);

    typedef enum logic [2:0] {
        S_WAIT,
        S_LATCH,
        S_READ,
        S_PULSE,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [UW-1:0] unit_cnt;
    logic [2:0]    bit_idx;
    logic          latch_half;
    logic [7:0]    shift_l;
    logic [7:0]    shift_r;
    logic          latch_q;
    logic          pulse_q;
    logic [7:0]    buttons_l_q;
    logic [7:0]    buttons_r_q;
    logic [7:0]    press_l_q;
    logic [7:0]    press_r_q;
    logic          frame_done_q;
    logic          busy_q;
    logic          poll_tc;
    logic          unit_end;

    assign poll_tc  = (poll_cnt == PW'(POLL_CYCLES - 1));
    assign unit_end = (unit_cnt == UW'(HALF_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else if (poll_tc) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_WAIT;
            unit_cnt     <= '0;
            bit_idx      <= '0;
            latch_half   <= 1'b0;
            shift_l      <= '0;
            shift_r      <= '0;
            latch_q      <= 1'b0;
            pulse_q      <= 1'b0;
            buttons_l_q  <= '0;
            buttons_r_q  <= '0;
            press_l_q    <= '0;
            press_r_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            press_l_q    <= '0;
            press_r_q    <= '0;
            case (state)
                S_WAIT: begin
                    unit_cnt <= '0;
                    if (poll_tc && bus.enable) begin
                        state      <= S_LATCH;
                        latch_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        latch_half <= 1'b0;
                    end
                end
                // Latch spans two unit periods; latch_half marks the second one.
                S_LATCH: begin
                    if (unit_end) begin
                        unit_cnt <= '0;
                        if (latch_half) begin
                            state   <= S_READ;
                            latch_q <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            latch_half <= 1'b1;
                        end
                    end else begin
                        unit_cnt <= unit_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (unit_end) begin
                        unit_cnt <= '0;
                        shift_l  <= {shift_l[6:0], bus.nes_data_l};
                        shift_r  <= {shift_r[6:0], bus.nes_data_r};
                        if (bit_idx == 3'd7) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_PULSE;
                            pulse_q <= 1'b1;
                        end
                    end else begin
                        unit_cnt <= unit_cnt + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (unit_end) begin
                        unit_cnt <= '0;
                        pulse_q  <= 1'b0;
                        bit_idx  <= bit_idx + 1'b1;
                        state    <= S_READ;
                    end else begin
                        unit_cnt <= unit_cnt + 1'b1;
                    end
                end
                // Lines are active-low; press compares against the previous frame.
                S_DONE: begin
                    buttons_l_q  <= ~shift_l;
                    buttons_r_q  <= ~shift_r;
                    press_l_q    <= ~shift_l & ~buttons_l_q;
                    press_r_q    <= ~shift_r & ~buttons_r_q;
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    unit_cnt     <= '0;
                    state        <= S_WAIT;
                end
                default: begin
                    state    <= S_WAIT;
                    unit_cnt <= '0;
                    latch_q  <= 1'b0;
                    pulse_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nes_latch  = latch_q;
    assign bus.nes_pulse  = pulse_q;
    assign bus.buttons_l  = buttons_l_q;
    assign bus.buttons_r  = buttons_r_q;
    assign bus.press_l    = press_l_q;
    assign bus.press_r    = press_r_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule
